// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode enumeration and flag bit positions for the ALU.
//   alu_op_e        : 5-bit opcode values driven on alu_ctrl
//   FLAG_N..FLAG_V  : bit indices of the {N,Z,C,V} flag nibble
package alu_pkg;

   typedef enum logic [4:0] {
      OP_ADD  = 5'd1,
      OP_SUB  = 5'd2,
      OP_MUL  = 5'd3,
      OP_MOV  = 5'd4,
      OP_DIV  = 5'd5,
      OP_LNUM = 5'd6,
      OP_AND  = 5'd9,
      OP_OR   = 5'd10,
      OP_XOR  = 5'd11,
      OP_NOT  = 5'd12
   } alu_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage : alu_pkg

// File: rtl/alu_lane_sel.sv
// alu_lane_sel: combinational lane extract.
//   lane_a   in  DATA_W : source word
//   lane_b   in  DATA_W : lane number, 1 = most significant lane
//   lane_out out DATA_W : selected lane zero-extended, 0 when lane_b is out of range
module alu_lane_sel #(
   parameter int LANE_W = 8,
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] lane_a,
   input  logic [DATA_W-1:0] lane_b,
   output logic [DATA_W-1:0] lane_out
);
   import alu_pkg::*;

   localparam int NUM_LANES = DATA_W / LANE_W;

   always_comb begin
      lane_out = '0;
      // Lane i occupies the i-th LANE_W slice counting down from the MSB.
      for (int i = 1; i <= NUM_LANES; i++) begin
         if (lane_b == DATA_W'(i)) begin
            lane_out[LANE_W-1:0] = lane_a[DATA_W - i*LANE_W +: LANE_W];
         end
      end
   end

endmodule : alu_lane_sel

// File: rtl/alu.sv
// alu: registered 32-bit integer ALU, one operation per enabled clock.
//   clk       in  1      : clock, rising edge
//   rst_n     in  1      : asynchronous active-low reset, clears result and flags
//   en        in  1      : load result/flags when 1, hold when 0
//   alu_ctrl  in  5      : opcode (alu_op_e)
//   srcA      in  DATA_W : operand A
//   srcB      in  DATA_W : operand B
//   result    out DATA_W : registered result
//   alu_flags out 4      : registered {N,Z,C,V}
module alu #(
   parameter int LANE_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [4:0]        alu_ctrl,
   input  logic [DATA_W-1:0] srcA,
   input  logic [DATA_W-1:0] srcB,
   output logic [DATA_W-1:0] result,
   output logic [3:0]        alu_flags
);
   import alu_pkg::*;

   localparam int MSB = DATA_W - 1;

   logic [DATA_W-1:0]   lane_res;
   logic [DATA_W:0]     sum_ext;
   logic [DATA_W:0]     diff_ext;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   result_d, result_q;
   logic [3:0]          flags_d, flags_q;
   logic                c_d, v_d;

   alu_lane_sel #(
      .LANE_W (LANE_W),
      .DATA_W (DATA_W)
   ) u_lane_sel (
      .lane_a   (srcA),
      .lane_b   (srcB),
      .lane_out (lane_res)
   );

   // Extra MSB of sum/diff holds carry out / borrow.
   assign sum_ext  = {1'b0, srcA} + {1'b0, srcB};
   assign diff_ext = {1'b0, srcA} - {1'b0, srcB};
   assign prod     = {{DATA_W{1'b0}}, srcA} * {{DATA_W{1'b0}}, srcB};

   always_comb begin
      result_d = '0;
      c_d      = 1'b0;
      v_d      = 1'b0;
      case (alu_ctrl)
         OP_ADD: begin
            result_d = sum_ext[DATA_W-1:0];
            c_d      = sum_ext[DATA_W];
            v_d      = (srcA[MSB] == srcB[MSB]) && (sum_ext[MSB] != srcA[MSB]);
         end
         OP_SUB: begin
            result_d = diff_ext[DATA_W-1:0];
            c_d      = ~diff_ext[DATA_W];
            v_d      = (srcA[MSB] != srcB[MSB]) && (diff_ext[MSB] != srcA[MSB]);
         end
         OP_MUL: begin
            result_d = prod[DATA_W-1:0];
            c_d      = |prod[2*DATA_W-1:DATA_W];
            v_d      = |prod[2*DATA_W-1:DATA_W];
         end
         OP_MOV:  result_d = srcA;
         OP_DIV: begin
            if (srcB == '0) begin
               result_d = '1;
               v_d      = 1'b1;
            end else begin
               result_d = srcA / srcB;
            end
         end
         OP_LNUM: result_d = lane_res;
         OP_AND:  result_d = srcA & srcB;
         OP_OR:   result_d = srcA | srcB;
         OP_XOR:  result_d = srcA ^ srcB;
         OP_NOT:  result_d = ~srcA;
         default: result_d = '0;
      endcase

      flags_d         = '0;
      flags_d[FLAG_N] = result_d[MSB];
      flags_d[FLAG_Z] = (result_d == '0);
      flags_d[FLAG_C] = c_d;
      flags_d[FLAG_V] = v_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         flags_q  <= '0;
      end else if (en) begin
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign result    = result_q;
   assign alu_flags = flags_q;

endmodule : alu

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu.
module tb_alu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [4:0]  alu_ctrl;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic [31:0] result;
   logic [3:0]  alu_flags;

   int n_checks = 0;
   int n_pass   = 0;

   alu #(.LANE_W(8), .DATA_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .alu_ctrl  (alu_ctrl),
      .srcA      (srcA),
      .srcB      (srcB),
      .result    (result),
      .alu_flags (alu_flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Apply one operation with en=1, then sample 1 time unit after the edge.
   task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic [3:0] exp_flg);
      alu_ctrl = op;
      srcA     = a;
      srcB     = b;
      en       = 1'b1;
      @(posedge clk);
      #1;
      check({tag, ".res"}, result, exp_res);
      check({tag, ".flg"}, {28'd0, alu_flags}, {28'd0, exp_flg});
   endtask

   initial begin
      rst_n    = 1'b1;
      en       = 1'b0;
      alu_ctrl = 5'd0;
      srcA     = '0;
      srcB     = '0;
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Load something nonzero, then reset between edges.
      do_op("pre_add", 5'd1, 32'd3, 32'd4, 32'd7, 4'b0000);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async.res", result, 32'd0);
      check("rst_async.flg", {28'd0, alu_flags}, 32'd0);
      alu_ctrl = 5'd1; srcA = 32'hFFFF_FFFF; srcB = 32'd1; en = 1'b1;
      @(posedge clk);
      #1;
      check("rst_hold.res", result, 32'd0);
      check("rst_hold.flg", {28'd0, alu_flags}, 32'd0);
      rst_n = 1'b1;

      do_op("add_1_5",   5'd1, 32'd1, 32'd5, 32'd6, 4'b0000);
      do_op("sub_2_1",   5'd2, 32'd2, 32'd1, 32'd1, 4'b0010);
      do_op("mul_2_8",   5'd3, 32'd2, 32'd8, 32'd16, 4'b0000);
      do_op("mov_15",    5'd4, 32'd15, 32'd99, 32'd15, 4'b0000);
      do_op("div_16_4",  5'd5, 32'd16, 32'd4, 32'd4, 4'b0000);
      do_op("div_by_0",  5'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 4'b1001);

      do_op("add_ovf",   5'd1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001);
      do_op("add_carry", 5'd1, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0110);
      do_op("sub_borrow",5'd2, 32'd1, 32'd2, 32'hFFFF_FFFF, 4'b1000);
      do_op("sub_eq",    5'd2, 32'd5, 32'd5, 32'd0, 4'b0110);
      do_op("mul_hi",    5'd3, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'b0111);

      do_op("lnum_1",    5'd6, 32'h080B_0A02, 32'd1, 32'h08, 4'b0000);
      do_op("lnum_2",    5'd6, 32'h080B_0A02, 32'd2, 32'h0B, 4'b0000);
      do_op("lnum_3",    5'd6, 32'h080B_0A02, 32'd3, 32'h0A, 4'b0000);
      do_op("lnum_4",    5'd6, 32'h080B_0A02, 32'd4, 32'h02, 4'b0000);
      do_op("lnum_0",    5'd6, 32'h080B_0A02, 32'd0, 32'd0, 4'b0100);
      do_op("lnum_5",    5'd6, 32'h080B_0A02, 32'd5, 32'd0, 4'b0100);

      do_op("and",       5'd9,  32'd1, 32'd1, 32'd1, 4'b0000);
      do_op("or",        5'd10, 32'd0, 32'd1, 32'd1, 4'b0000);
      do_op("xor",       5'd11, 32'd0, 32'd1, 32'd1, 4'b0000);
      do_op("not",       5'd12, 32'd0, 32'd0, 32'hFFFF_FFFF, 4'b1000);
      do_op("op7",       5'd7,  32'd3, 32'd4, 32'd0, 4'b0100);

      // Hold with en low while operands change.
      do_op("hold_add",  5'd1, 32'd1, 32'd5, 32'd6, 4'b0000);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         alu_ctrl = 5'd2;
         srcA     = 32'd100 + 32'(i);
         srcB     = 32'd200;
         @(posedge clk);
         #1;
         check("hold.res", result, 32'd6);
         check("hold.flg", {28'd0, alu_flags}, 32'd0);
      end
      do_op("xor_3_1",   5'd11, 32'd3, 32'd1, 32'd2, 4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_alu

// File: doc/alu.md
# alu

Registered 32-bit integer ALU for the processor datapath. It executes one operation per enabled clock on operands `srcA`/`srcB`, selected by a 5-bit opcode. Operations are add, subtract, multiply, move, divide, byte-lane extract (LNUM) and bitwise logic. It drives a registered result and an NZCV flag nibble to the writeback and branch logic.

## Interface
- `LANE_W`, default 8: width of one lane for LNUM; first positional parameter.
- `DATA_W`, default 32: operand and result width; must be a multiple of `LANE_W`.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: when 1, the output registers load the new result and flags at the clock edge; when 0, they hold.
- `alu_ctrl` input 5: opcode.
- `srcA` input DATA_W: operand A.
- `srcB` input DATA_W: operand B.
- `result` output DATA_W: registered result.
- `alu_flags` output 4: registered flags {N,Z,C,V}, with bit 3 = N.

## Operation
- Opcodes, all unsigned except V:
  - 1 ADD: A+B.
  - 2 SUB: A−B.
  - 3 MUL: low DATA_W bits of A*B.
  - 4 MOV: result = A; B is ignored.
  - 5 DIV: A/B truncated.
  - 6 LNUM: lane extract (rule below).
  - 9 AND: A&B.
  - 10 OR: A|B.
  - 11 XOR: A^B.
  - 12 NOT: ~A.
- Any other code (0, 7, 8, 13–31): result 0.
- LNUM: lanes are numbered 1..DATA_W/LANE_W starting from the most significant lane.
  - Result = lane B, zero-extended.
  - B = 0 or B > lane count: result 0.
  - Example: A = 0x080B0A02, B = 3 → 0x0000000A.
- DIV by zero: result = all ones, V = 1.
- N = result[DATA_W-1] and Z = (result == 0), for every opcode.
- C:
  - ADD: carry out.
  - SUB: 1 when no borrow (A ≥ B).
  - MUL: 1 when the upper DATA_W bits of the full 2·DATA_W product are nonzero.
  - All other opcodes: 0.
- V:
  - ADD/SUB: two's-complement signed overflow.
  - MUL: same as C.
  - DIV: 1 only on divide by zero.
  - All other opcodes: 0.
- Next-state logic is fully combinational, with no multi-cycle divider.

## Timing
- Latency is 1 cycle: inputs sampled at edge k with `en` = 1 appear on `result`/`alu_flags` after edge k.
- `en` = 0 at an edge: outputs hold their previous value; inputs are don't-care.
- Reset asserted at any time, including mid-stream: `result` = 0 and `alu_flags` = 4'b0000 immediately, without waiting for a clock edge. Both stay at 0 while `rst_n` = 0.
- First load after deassertion: the first rising edge with `rst_n` = 1 and `en` = 1.
- There is no handshake, stall or backpressure; a new operation may be issued every cycle.

## Structure
- Shared package `alu_pkg` holds:
  - the enum `alu_op_e` with the opcode values listed above;
  - the flag bit-index constants `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
- One sub-module, `alu_lane_sel`: parameterised by `LANE_W`/`DATA_W`. It takes A and B, returns the LNUM result, and is purely combinational.
- Top level contains the opcode case, the flag generation and the output registers.

## Test plan
- Reset: assert `rst_n` = 0 between clock edges → `result` = 0 and `alu_flags` = 0 without an edge. Release, then `en` = 1 with ADD 1+5 → `result` = 6 and flags 0000 after one edge.
- Arithmetic, one per cycle with `en` = 1:
  - SUB 2−1 → 1 with C = 1.
  - MUL 2*8 → 16.
  - MOV A = 15 → 15.
  - DIV 16/4 → 4.
  - DIV 5/0 → 0xFFFFFFFF with N = 1, V = 1.
- Flag corners:
  - ADD 0x7FFFFFFF+1 → 0x80000000 with N = 1, V = 1.
  - ADD 0xFFFFFFFF+1 → 0 with Z = 1, C = 1.
  - SUB 1−2 → 0xFFFFFFFF with C = 0.
  - MUL 0x10000*0x10000 → 0 with C = V = 1.
- LNUM with A = 0x080B0A02:
  - B = 1 → 0x08.
  - B = 2 → 0x0B.
  - B = 3 → 0x0A.
  - B = 4 → 0x02.
  - B = 0 → 0.
  - B = 5 → 0.
- Logic:
  - AND 1&1 → 1.
  - OR 0|1 → 1.
  - XOR 0^1 → 1.
  - NOT 0 → 0xFFFFFFFF (N = 1).
  - Opcode 7 → 0 with Z = 1.
- Hold: issue ADD 1+5, then drive `en` = 0 with new operands for 3 cycles → `result` stays 6. Then `en` = 1 with XOR 3^1 → 2 on the next edge.
